// File: rtl/reg_copy_engine_if.sv
// Read and write register-bus interfaces between the copy engine and the interconnect.
// The master drives addr/valid (and data on writes); the slave answers with ready (and data on reads).
interface r_busif #(
    parameter int AW = 8,
    parameter int DW = 32
) ();
    logic [AW-1:0] addr;
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;

    modport master (output addr, output valid, input data, input ready);
    modport slave  (input addr, input valid, output data, output ready);
endinterface

interface w_busif #(
    parameter int AW = 8,
    parameter int DW = 32
) ();
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;

    modport master (output addr, output data, output valid, input ready);
    modport slave  (input addr, input data, input valid, output ready);
endinterface

// File: rtl/reg_copy_engine.sv
// Word-by-word register copy engine: reads a source word, writes it to the
// destination, and repeats strictly forward until length is reached or an abort lands.
module reg_copy_engine #(
    parameter int  REG_DEPTH    = 256,
    parameter int  DATA_WIDTH   = 32,
    localparam int LB_REG_DEPTH = $clog2(REG_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [LB_REG_DEPTH-1:0] src_base,
    input  logic [LB_REG_DEPTH-1:0] dst_base,
    input  logic [LB_REG_DEPTH:0]   length,
    input  logic                    abort,
    r_busif.master                  r_m,
    w_busif.master                  w_m,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [LB_REG_DEPTH:0]   copied
);

    localparam logic [LB_REG_DEPTH:0] DEPTH_W = (LB_REG_DEPTH+1)'(REG_DEPTH);
    localparam logic [LB_REG_DEPTH:0] ONE_W   = (LB_REG_DEPTH+1)'(1);
    localparam logic [LB_REG_DEPTH:0] ZERO_W  = (LB_REG_DEPTH+1)'(0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_r;
    logic [LB_REG_DEPTH-1:0] src_r;
    logic [LB_REG_DEPTH-1:0] dst_r;
    logic [LB_REG_DEPTH:0]   len_r;
    logic [LB_REG_DEPTH:0]   copied_r;
    logic [LB_REG_DEPTH-1:0] r_addr_r;
    logic [LB_REG_DEPTH-1:0] w_addr_r;
    logic [DATA_WIDTH-1:0]   buf_r;
    logic                    r_valid_r;
    logic                    w_valid_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    aborted_r;
    logic                    abort_pend_r;

    logic [LB_REG_DEPTH:0]   len_clamp_s;
    logic [LB_REG_DEPTH:0]   copied_inc_s;
    logic                    stop_s;

    // Requests longer than the register file copy every register exactly once.
    assign len_clamp_s  = (length > DEPTH_W) ? DEPTH_W : length;
    assign copied_inc_s = copied_r + ONE_W;
    assign stop_s       = (copied_inc_s == len_r) || abort_pend_r || abort;

    assign r_m.addr  = r_addr_r;
    assign r_m.valid = r_valid_r;
    assign w_m.addr  = w_addr_r;
    assign w_m.data  = buf_r;
    assign w_m.valid = w_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign aborted   = aborted_r;
    assign copied    = copied_r;

    // Copy FSM; address adds drop the carry, so wrap relies on REG_DEPTH being a power of two.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r      <= IDLE;
            src_r        <= '0;
            dst_r        <= '0;
            len_r        <= ZERO_W;
            copied_r     <= ZERO_W;
            r_addr_r     <= '0;
            w_addr_r     <= '0;
            buf_r        <= '0;
            r_valid_r    <= 1'b0;
            w_valid_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            aborted_r    <= 1'b0;
            abort_pend_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        src_r        <= src_base;
                        dst_r        <= dst_base;
                        len_r        <= len_clamp_s;
                        copied_r     <= ZERO_W;
                        aborted_r    <= 1'b0;
                        abort_pend_r <= 1'b0;
                        busy_r       <= 1'b1;
                        if (length == ZERO_W) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r   <= RD;
                            r_valid_r <= 1'b1;
                            r_addr_r  <= src_base;
                        end
                    end
                end
                RD: begin
                    if (abort) begin
                        abort_pend_r <= 1'b1;
                    end
                    if (r_valid_r && r_m.ready) begin
                        buf_r     <= r_m.data;
                        r_valid_r <= 1'b0;
                        w_valid_r <= 1'b1;
                        w_addr_r  <= dst_r + copied_r[LB_REG_DEPTH-1:0];
                        state_r   <= WR;
                    end
                end
                WR: begin
                    if (abort) begin
                        abort_pend_r <= 1'b1;
                    end
                    if (w_valid_r && w_m.ready) begin
                        copied_r  <= copied_inc_s;
                        w_valid_r <= 1'b0;
                        if (stop_s) begin
                            state_r   <= DONE;
                            done_r    <= 1'b1;
                            aborted_r <= abort_pend_r || abort;
                        end else begin
                            state_r   <= RD;
                            r_valid_r <= 1'b1;
                            r_addr_r  <= src_r + copied_inc_s[LB_REG_DEPTH-1:0];
                        end
                    end
                end
                DONE: begin
                    done_r       <= 1'b0;
                    busy_r       <= 1'b0;
                    abort_pend_r <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    r_valid_r <= 1'b0;
                    w_valid_r <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_copy_engine.sv
// Self-checking bench for reg_copy_engine: a register-file slave model plus a
// forward-copy reference model of the expected memory contents.
module tb_reg_copy_engine;

    logic        clk = 1'b0;
    logic        rstn, start, abort;
    logic [7:0]  src_base, dst_base;
    logic [8:0]  length;
    logic        busy, done, aborted;
    logic [8:0]  copied;
    logic        r_ready, w_ready;
    int          ready_mode;

    logic [31:0] mem [256];
    logic [31:0] exp_mem [256];
    logic [7:0]  rd_log [$];
    logic [7:0]  wr_log [$];
    int          checks, errors, done_cnt;

    logic        prev_rstn, prev_rv, prev_rr, prev_wv, prev_wr;
    logic [7:0]  prev_ra, prev_wa;
    logic [31:0] prev_wd;

    r_busif #(.AW(8), .DW(32)) r_bus ();
    w_busif #(.AW(8), .DW(32)) w_bus ();

    reg_copy_engine #(.REG_DEPTH(256), .DATA_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .start(start), .src_base(src_base), .dst_base(dst_base),
        .length(length), .abort(abort), .r_m(r_bus), .w_m(w_bus),
        .busy(busy), .done(done), .aborted(aborted), .copied(copied)
    );

    always #5 clk = ~clk;

    assign r_bus.data  = mem[r_bus.addr];
    assign r_bus.ready = r_ready;
    assign w_bus.ready = w_ready;

    // Ready driver: 0 = always ready, 1 = random, other = stalled.
    always @(negedge clk) begin
        if (ready_mode == 0) begin
            r_ready = 1'b1; w_ready = 1'b1;
        end else if (ready_mode == 1) begin
            r_ready = ($urandom_range(0, 3) != 0); w_ready = ($urandom_range(0, 3) != 0);
        end else begin
            r_ready = 1'b0; w_ready = 1'b0;
        end
    end

    // Slave side: perform writes, log handshakes, watch bus-protocol rules.
    always @(posedge clk) begin
        if (r_bus.valid === 1'b1 && r_ready) rd_log.push_back(r_bus.addr);
        if (w_bus.valid === 1'b1 && w_ready) begin
            wr_log.push_back(w_bus.addr);
            mem[w_bus.addr] = w_bus.data;
        end
        if (done === 1'b1) done_cnt++;
        checks++;
        if (r_bus.valid === 1'b1 && w_bus.valid === 1'b1) begin
            errors++; $display("FAIL both_valid got r=1 w=1 exp not both");
        end
        if (prev_rstn && prev_rv && !prev_rr) begin
            checks++;
            if (r_bus.valid !== 1'b1 || r_bus.addr !== prev_ra) begin
                errors++; $display("FAIL rd_hold got v=%b a=%h exp v=1 a=%h", r_bus.valid, r_bus.addr, prev_ra);
            end
        end
        if (prev_rstn && prev_wv && !prev_wr) begin
            checks++;
            if (w_bus.valid !== 1'b1 || w_bus.addr !== prev_wa || w_bus.data !== prev_wd) begin
                errors++; $display("FAIL wr_hold got v=%b a=%h d=%h exp v=1 a=%h d=%h",
                                   w_bus.valid, w_bus.addr, w_bus.data, prev_wa, prev_wd);
            end
        end
        prev_rstn = rstn; prev_rv = (r_bus.valid === 1'b1); prev_rr = r_ready; prev_ra = r_bus.addr;
        prev_wv = (w_bus.valid === 1'b1); prev_wr = w_ready; prev_wa = w_bus.addr; prev_wd = w_bus.data;
    end

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom; exp_mem[i] = mem[i];
        end
    endtask

    // Reference: words move one at a time in increasing order, addresses wrap at 256.
    task automatic model_copy(input int s, input int d, input int l);
        int n;
        n = (l > 256) ? 256 : l;
        for (int i = 0; i < n; i++) exp_mem[(d + i) % 256] = exp_mem[(s + i) % 256];
    endtask

    function automatic int mem_diffs();
        int c = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) c++;
        return c;
    endfunction

    // Pulse start for one cycle; returns at the first negedge after start was sampled.
    task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l, input bit with_abort);
        rd_log.delete(); wr_log.delete();
        @(negedge clk);
        src_base = s; dst_base = d; length = l; start = 1'b1; abort = with_abort;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_done(output int n, output bit ok);
        ok = 1'b0; n = 0;
        for (int i = 0; i < 4000; i++) begin
            if (done === 1'b1) begin ok = 1'b1; n = i; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL done_timeout got no done exp done within 4000 cycles"); end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; abort = 1'b0; src_base = 8'h00; dst_base = 8'h00; length = 9'd0;
        ready_mode = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, aborted, r_bus.valid, w_bus.valid} !== 5'b0 || copied !== 9'd0 ||
            r_bus.addr !== 8'h00 || w_bus.addr !== 8'h00 || w_bus.data !== 32'h0) begin
            errors++; $display("FAIL reset_vals got b=%b d=%b ab=%b rv=%b wv=%b c=%0d ra=%h wa=%h wd=%h exp all 0",
                               busy, done, aborted, r_bus.valid, w_bus.valid, copied, r_bus.addr, w_bus.addr, w_bus.data);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n, d0; bit ok;
        ready_mode = 0; fill_mem(); model_copy(16, 128, 4); d0 = done_cnt;
        launch(8'h10, 8'h80, 9'd4, 1'b1);
        checks++;
        if (busy !== 1'b1 || r_bus.valid !== 1'b1 || r_bus.addr !== 8'h10) begin
            errors++; $display("FAIL basic_rd_entry got b=%b rv=%b ra=%h exp 1 1 10", busy, r_bus.valid, r_bus.addr);
        end
        wait_done(n, ok);
        checks++;
        if (n != 8) begin errors++; $display("FAIL basic_latency got %0d exp 8", n); end
        checks++;
        if (copied !== 9'd4 || aborted !== 1'b0) begin
            errors++; $display("FAIL basic_status got c=%0d ab=%b exp 4 0", copied, aborted);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL basic_pulse got d=%b b=%b pulses=%0d exp 0 0 1", done, busy, done_cnt - d0);
        end
        checks++;
        if (mem_diffs() != 0) begin errors++; $display("FAIL basic_mem got %0d diffs exp 0", mem_diffs()); end
    endtask

    task automatic test_zero_len();
        int n; bit ok;
        ready_mode = 0; fill_mem();
        launch(8'h33, 8'h44, 9'd0, 1'b0);
        wait_done(n, ok);
        checks++;
        if (n != 0 || copied !== 9'd0) begin errors++; $display("FAIL zero_done got n=%0d c=%0d exp 0 0", n, copied); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || rd_log.size() != 0 || wr_log.size() != 0 || mem_diffs() != 0) begin
            errors++; $display("FAIL zero_bus got d=%b rd=%0d wr=%0d diffs=%0d exp 0 0 0 0",
                               done, rd_log.size(), wr_log.size(), mem_diffs());
        end
    endtask

    task automatic test_wrap();
        int n, bad, s, d; bit ok;
        ready_mode = 0; fill_mem(); model_copy(254, 0, 4);
        launch(8'hFE, 8'h00, 9'd4, 1'b0);
        wait_done(n, ok);
        bad = (rd_log.size() != 4 || wr_log.size() != 4) ? 1 : 0;
        for (int i = 0; i < 4 && bad == 0; i++) begin
            if (rd_log[i] != 8'((254 + i) % 256)) bad = 1;
            if (wr_log[i] != 8'(i)) bad = 1;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL wrap_order got rd=%p wr=%p exp rd=fe,ff,00,01 wr=00..03", rd_log, wr_log);
        end
        checks++;
        if (mem_diffs() != 0) begin errors++; $display("FAIL wrap_mem got %0d diffs exp 0", mem_diffs()); end
        @(negedge clk);
        ready_mode = 1; fill_mem();
        s = $urandom_range(0, 255); d = $urandom_range(0, 255);
        model_copy(s, d, 300);
        launch(8'(s), 8'(d), 9'd300, 1'b0);
        wait_done(n, ok);
        checks++;
        if (copied !== 9'd256 || wr_log.size() != 256) begin
            errors++; $display("FAIL clamp_count got c=%0d wr=%0d exp 256 256", copied, wr_log.size());
        end
        checks++;
        if (mem_diffs() != 0) begin errors++; $display("FAIL clamp_mem got %0d diffs exp 0", mem_diffs()); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int n, s, d, l; bit ok;
        ready_mode = 1; fill_mem();
        for (int t = 0; t < 6; t++) begin
            s = $urandom_range(0, 255); d = $urandom_range(0, 255); l = $urandom_range(1, 40);
            model_copy(s, d, l);
            launch(8'(s), 8'(d), 9'(l), 1'b0);
            wait_done(n, ok);
            checks++;
            if (copied !== 9'(l) || aborted !== 1'b0 || mem_diffs() != 0) begin
                errors++; $display("FAIL random_copy got c=%0d ab=%b diffs=%0d exp %0d 0 0", copied, aborted, mem_diffs(), l);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort_stall();
        int n, s, d; bit ok;
        fill_mem(); ready_mode = 2; r_ready = 1'b0; w_ready = 1'b0;
        s = $urandom_range(0, 255); d = $urandom_range(0, 255);
        model_copy(s, d, 1);
        launch(8'(s), 8'(d), 9'd8, 1'b0);
        for (int k = 0; k < 5; k++) begin
            abort = (k == 1);
            @(negedge clk);
        end
        abort = 1'b0;
        checks++;
        if (rd_log.size() != 0 || r_bus.valid !== 1'b1 || r_bus.addr !== 8'(s)) begin
            errors++; $display("FAIL abort_stall got rd=%0d rv=%b ra=%h exp 0 1 %h", rd_log.size(), r_bus.valid, r_bus.addr, 8'(s));
        end
        ready_mode = 0; r_ready = 1'b1; w_ready = 1'b1;
        wait_done(n, ok);
        checks++;
        if (aborted !== 1'b1 || copied !== 9'd1 || wr_log.size() != 1 || mem_diffs() != 0) begin
            errors++; $display("FAIL abort_result got ab=%b c=%0d wr=%0d diffs=%0d exp 1 1 1 0",
                               aborted, copied, wr_log.size(), mem_diffs());
        end
        @(negedge clk);
    endtask

    task automatic test_start_busy();
        int n, s, d, d0; bit ok;
        ready_mode = 1; fill_mem(); d0 = done_cnt;
        s = $urandom_range(0, 255); d = $urandom_range(0, 255);
        model_copy(s, d, 6);
        launch(8'(s), 8'(d), 9'd6, 1'b0);
        @(negedge clk);
        src_base = 8'(s + 50); dst_base = 8'(d + 90); length = 9'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, ok);
        checks++;
        if (copied !== 9'd6 || wr_log.size() != 6 || mem_diffs() != 0) begin
            errors++; $display("FAIL busy_start got c=%0d wr=%0d diffs=%0d exp 6 6 0", copied, wr_log.size(), mem_diffs());
        end
        @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL busy_pulses got pulses=%0d b=%b exp 1 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int n, s, d, nw, d0; bit ok, found;
        ready_mode = 0; fill_mem(); found = 1'b0;
        s = $urandom_range(0, 255); d = $urandom_range(0, 255);
        launch(8'(s), 8'(d), 9'd10, 1'b0);
        for (int i = 0; i < 10 && !found; i++) begin
            if (w_bus.valid === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rst_reach_wr got no WR exp WR within 10 cycles"); end
        ready_mode = 2; r_ready = 1'b0; w_ready = 1'b0; rstn = 1'b0;
        nw = wr_log.size(); d0 = done_cnt;
        @(negedge clk);
        checks++;
        if ({busy, done, aborted, r_bus.valid, w_bus.valid} !== 5'b0 || copied !== 9'd0 ||
            r_bus.addr !== 8'h00 || w_bus.addr !== 8'h00 || w_bus.data !== 32'h0) begin
            errors++; $display("FAIL rst_mid_vals got b=%b d=%b ab=%b rv=%b wv=%b c=%0d exp all 0",
                               busy, done, aborted, r_bus.valid, w_bus.valid, copied);
        end
        rstn = 1'b1; ready_mode = 0;
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt != d0 || wr_log.size() != nw || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_quiet got pulses=%0d wr=%0d b=%b exp 0 %0d 0", done_cnt - d0, wr_log.size(), busy, nw);
        end
        model_copy(s, d, nw);
        s = $urandom_range(0, 255); d = $urandom_range(0, 255);
        model_copy(s, d, 5);
        launch(8'(s), 8'(d), 9'd5, 1'b0);
        wait_done(n, ok);
        checks++;
        if (n != 10 || copied !== 9'd5 || aborted !== 1'b0 || mem_diffs() != 0) begin
            errors++; $display("FAIL rst_mid_after got n=%0d c=%0d ab=%b diffs=%0d exp 10 5 0 0", n, copied, aborted, mem_diffs());
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0; done_cnt = 0;
        prev_rstn = 1'b0; prev_rv = 1'b0; prev_rr = 1'b0; prev_wv = 1'b0; prev_wr = 1'b0;
        prev_ra = 8'h00; prev_wa = 8'h00; prev_wd = 32'h0;
        r_ready = 1'b1; w_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin mem[i] = 32'h0; exp_mem[i] = 32'h0; end
        test_reset();
        test_basic();
        test_zero_len();
        test_wrap();
        test_random();
        test_abort_stall();
        test_start_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
